// File: rtl/alu_operand_seq.sv
// alu_operand_seq: operand sequencer sitting upstream of a combinational 4-bit alu.
// Holds a small register file (r0 reads as zero), accepts one instruction at a time,
// drives the alu operands from registers, then captures R and the flags and writes R back.
// Optional build macro: OVERFLOW_FLAG_EN adds input alu_v and output flag_v.
module alu_operand_seq #(
    parameter int WIDTH  = 4,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic              instr_l,
    input  logic [REG_AW-1:0] instr_ra,
    input  logic [REG_AW-1:0] instr_rb,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic              instr_we,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [WIDTH-1:0]  ld_data,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [1:0]        alu_op,
    output logic              alu_l,
    input  logic [WIDTH-1:0]  alu_r,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_s,
`ifdef OVERFLOW_FLAG_EN
    input  logic              alu_v,
    output logic              flag_v,
`endif
    output logic [WIDTH-1:0]  result,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_s,
    output logic              done,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int unsigned NREG = 2 ** REG_AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [REG_AW-1:0] rd_q;
    logic              we_q;
    logic [WIDTH-1:0]  alu_a_q, alu_b_q;
    logic [1:0]        alu_op_q;
    logic              alu_l_q;
    logic [WIDTH-1:0]  result_q;
    logic              flag_z_q, flag_c_q, flag_s_q;
`ifdef OVERFLOW_FLAG_EN
    logic              flag_v_q;
`endif
    logic              done_q;
    logic [WIDTH-1:0]  rf_q [NREG];

    logic              accept;
    logic              wb_we;
    logic              ld_we;
    logic [WIDTH-1:0]  rd_a, rd_b;

    // Handshake, write enables and r0-masked register reads
    always_comb begin
        accept = (state_q == S_IDLE) && instr_valid;
        wb_we  = (state_q == S_WB) && we_q && (rd_q != '0);
        ld_we  = (state_q == S_IDLE) && ld_en && (ld_addr != '0);
        rd_a   = (instr_ra == '0) ? '0 : rf_q[instr_ra];
        rd_b   = (instr_rb == '0) ? '0 : rf_q[instr_rb];
    end

    // Next-state logic: IDLE -> EXEC -> WB -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and instruction/operand/result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rd_q     <= '0;
            we_q     <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            alu_l_q  <= 1'b0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_s_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            flag_v_q <= 1'b0;
`endif
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Operands are read before any same-edge load lands, so they see pre-load values
                alu_a_q  <= rd_a;
                alu_b_q  <= rd_b;
                alu_op_q <= instr_op;
                alu_l_q  <= instr_l;
                rd_q     <= instr_rd;
                we_q     <= instr_we;
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_r;
                flag_z_q <= alu_z;
                flag_c_q <= alu_c;
                flag_s_q <= alu_s;
`ifdef OVERFLOW_FLAG_EN
                flag_v_q <= alu_v;
`endif
                done_q   <= 1'b1;
            end else begin
                done_q   <= 1'b0;
            end
        end
    end

    // Register file: writeback in WB, direct load only in IDLE; r0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we) begin
            rf_q[rd_q] <= result_q;
        end else if (ld_we) begin
            rf_q[ld_addr] <= ld_data;
        end
    end

    // Debug read port
    always_comb begin
        dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
    end

    assign instr_ready = (state_q == S_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign alu_l       = alu_l_q;
    assign result      = result_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
    assign flag_s      = flag_s_q;
`ifdef OVERFLOW_FLAG_EN
    assign flag_v      = flag_v_q;
`endif
    assign done        = done_q;

endmodule
